latch_q: RTL and testbench



---
 rtl/latch_q_pkg.sv | 27 ++
 rtl/latch_q_if.sv | 37 +++
 rtl/latch_q_mem.sv | 33 +++
 rtl/latch_q.sv | 129 ++++++++++++
 tb/tb_latch_q.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/latch_q_pkg.sv
// latch_q_pkg: shared definitions for the latch_q holding queue.
//   DEF_SIZE / DEF_DEPTH : default word width and queue depth
//   state_t              : ready-flag state encoding (ST_EMPTY, ST_HOLD)
//   clog2()              : ceiling log2, used for pointer and counter widths
package latch_q_pkg;

    localparam int DEF_SIZE  = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Number of bits needed to hold values 0..value-1 (0 for value<=1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/latch_q_if.sv
// latch_q_if: producer/consumer bus of the latch_q holding queue.
//   in_b, en        : capture data and strobe (producer -> queue)
//   out_b, rdyq     : head word and head-valid flag (queue -> consumer)
//   ack             : consumer pop
//   full, count     : occupancy status
//   ovf, ovf_clr    : sticky overflow flag and its clear
// master modport is the user side, slave modport is the queue itself.
interface latch_q_if
    import latch_q_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int DEPTH = DEF_DEPTH
) ();

    localparam int CW = clog2(DEPTH + 1);

    logic [SIZE-1:0] in_b;
    logic            en;
    logic [SIZE-1:0] out_b;
    logic            rdyq;
    logic            ack;
    logic            full;
    logic [CW-1:0]   count;
    logic            ovf;
    logic            ovf_clr;

    modport master (
        output in_b, en, ack, ovf_clr,
        input  out_b, rdyq, full, count, ovf
    );

    modport slave (
        input  in_b, en, ack, ovf_clr,
        output out_b, rdyq, full, count, ovf
    );

endinterface

// File: rtl/latch_q_mem.sv
// latch_q_mem: DEPTH x SIZE register array for the holding queue.
//   clk, reset : clock and synchronous active-high reset (clears every entry)
//   we, waddr, wdata : clock-enabled write port
//   raddr, rdata     : asynchronous read port
module latch_q_mem #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [PW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [PW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);

    logic [SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/latch_q.sv
// latch_q: first-word-fall-through holding queue with ready flag.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : latch_q_if.slave (in_b/en capture, out_b/rdyq/ack head,
//           full/count occupancy, ovf/ovf_clr sticky overflow)
// Build option LATCH_Q_HOLD_LAST_EN: when empty, out_b shows the last
// popped word instead of 0.
//
// state    | meaning
// ---------+-----------------------------------------
// ST_EMPTY | no word held, rdyq=0
// ST_HOLD  | at least one word held, head on out_b, rdyq=1
module latch_q
    import latch_q_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic       clk,
    input logic       reset,
    latch_q_if.slave  bus
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = clog2(DEPTH);

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   raddr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_nxt;
    logic            full_q;
    logic            ovf_q;
    logic            rdyq;
    logic            push;
    logic            pop;
    logic            ovf_set;
    logic [SIZE-1:0] head;

    assign rdyq    = (state == ST_HOLD);
    assign pop     = bus.ack & rdyq;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push    = bus.en & (~full_q | pop);
    assign ovf_set = bus.en & full_q & ~pop;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pop && !push && (count_q == CW'(1))) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_EMPTY;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            count_q <= count_nxt;
            full_q  <= (count_nxt == CW'(DEPTH));
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef LATCH_Q_HOLD_LAST_EN
    // While empty, the entry just behind rd_ptr is the last popped word; it
    // cannot be overwritten until the queue has refilled past it.
    assign raddr     = rdyq ? rd_ptr : (rd_ptr - PW'(1));
    assign bus.out_b = head;
`else
    assign raddr     = rd_ptr;
    assign bus.out_b = rdyq ? head : '0;
`endif

    latch_q_mem #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.in_b),
        .raddr (raddr),
        .rdata (head)
    );

    assign bus.rdyq  = rdyq;
    assign bus.full  = full_q;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_latch_q.sv
// tb_latch_q: scoreboard bench for latch_q (SIZE=8, DEPTH=4).
// The driver applies one stimulus per cycle, advances a queue-based model
// and pushes the expected post-edge outputs; the monitor pops and compares.
module tb_latch_q;

    localparam int SIZE  = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] out_b;
        logic       rdyq;
        logic       full;
        logic [2:0] count;
        logic       ovf;
    } snap_t;

    logic clk;
    logic reset;

    latch_q_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

    latch_q #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snap_t      exp_q[$];
    logic [7:0] model_q[$];
    logic [7:0] last_pop;
    logic       model_ovf;
    int         n_vec;
    int         n_err;

    function automatic bit chk(string nm, int got, int want);
        if (got != want) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Monitor: the DUT presents its outputs every cycle after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                snap_t e;
                bit    bad;
                e   = exp_q.pop_front();
                bad = 1'b0;
                bad |= chk("out_b", int'(bus.out_b), int'(e.out_b));
                bad |= chk("rdyq",  int'(bus.rdyq),  int'(e.rdyq));
                bad |= chk("full",  int'(bus.full),  int'(e.full));
                bad |= chk("count", int'(bus.count), int'(e.count));
                bad |= chk("ovf",   int'(bus.ovf),   int'(e.ovf));
                n_vec++;
                if (bad) n_err++;
            end
        end
    end

    task automatic step(input bit rst, input bit en, input bit ack,
                        input bit clr, input logic [7:0] din);
        snap_t s;
        bit    can_pop;
        bit    can_push;
        bit    dropped;
        @(negedge clk);
        reset       = rst;
        bus.en      = en;
        bus.ack     = ack;
        bus.ovf_clr = clr;
        bus.in_b    = din;
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
            last_pop  = 8'h00;
        end else begin
            can_pop  = ack && (model_q.size() > 0);
            dropped  = en && (model_q.size() == DEPTH) && !can_pop;
            can_push = en && !dropped;
            if (can_pop)  last_pop = model_q.pop_front();
            if (can_push) model_q.push_back(din);
            if (dropped)  model_ovf = 1'b1;
            else if (clr) model_ovf = 1'b0;
        end
        s.rdyq  = (model_q.size() > 0);
        s.count = 3'(model_q.size());
        s.full  = (model_q.size() == DEPTH);
        s.ovf   = model_ovf;
`ifdef LATCH_Q_HOLD_LAST_EN
        s.out_b = s.rdyq ? model_q[0] : last_pop;
`else
        s.out_b = s.rdyq ? model_q[0] : 8'h00;
`endif
        exp_q.push_back(s);
    endtask

    task automatic push_w(input logic [7:0] d);
        step(0, 1, 0, 0, d);
    endtask

    task automatic pop_w();
        step(0, 0, 1, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] d;
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        bus.en      = 1'b0;
        bus.ack     = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.in_b    = 8'h00;
        model_ovf   = 1'b0;
        last_pop    = 8'h00;

        step(1, 0, 0, 0, 8'h00);
        step(1, 1, 1, 1, 8'hFF);

        // single push then ack
        push_w(8'hA5);
        step(0, 0, 0, 0, 8'h00);
        pop_w();
        step(0, 0, 0, 0, 8'h00);

        // fill, overflow, drain
        for (int i = 1; i <= 4; i++) push_w(8'(i));
        push_w(8'h05);
        step(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) pop_w();
        step(0, 0, 0, 1, 8'h00);

        // full with en&ack
        for (int i = 1; i <= 4; i++) push_w(8'(i));
        step(0, 1, 1, 0, 8'h10);
        for (int i = 0; i < 5; i++) pop_w();

        // empty with en&ack
        step(0, 1, 1, 0, 8'h3C);
        pop_w();

        // wrap-around push/pop pairs
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            push_w(d);
            pop_w();
        end

        // overflow together with ovf_clr, then clear
        for (int i = 0; i < 4; i++) push_w(8'($urandom));
        step(0, 1, 0, 1, 8'hEE);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) pop_w();

        // reset mid-burst with en held
        for (int i = 0; i < 3; i++) push_w(8'($urandom));
        push_w(8'h77);
        push_w(8'h78);
        step(1, 1, 0, 0, 8'h99);
        step(0, 0, 1, 0, 8'h00);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) < 2,
                 $urandom_range(99) < 60,
                 $urandom_range(99) < 50,
                 $urandom_range(99) < 10,
                 8'($urandom));
        end
        step(0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            n_err++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
